// File: rtl/abs_diff_pkg.sv
// Shared definitions for the |A-B| datapath: FSM encoding and width derivation
// helpers used by both the subtractor and the accumulator.
package abs_diff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Subtractor result width: |A-B| of two WIDTH-bit products plus carry.
    function automatic int calc_dw(input int width);
        return 2 * width + 1;
    endfunction

    // Wide enough that 2^CNT_WIDTH-1 samples of DW bits can never overflow.
    function automatic int calc_sum_width(input int dw, input int cnt_width);
        return dw + cnt_width;
    endfunction

endpackage

// File: rtl/abs_diff_accumulator_frame_counter.sv
// Sample counter for one frame: loads the frame length, counts accepted samples
// and flags when the next accept completes the frame.
module frame_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] len_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            cnt   <= '0;
        end else if (clear) begin
            len_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            len_q <= len;
            cnt   <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    // len_q is never 0 while counting, so cnt+1 cannot wrap before matching.
    assign last = (cnt + CNT_WIDTH'(1)) == len_q;

endmodule

// File: rtl/abs_diff_accumulator.sv
// Frame accumulator for |A-B| samples: exact sum, maximum and count per frame,
// reported over a valid/ready result handshake.
module abs_diff_accumulator
    import abs_diff_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DW        = calc_dw(WIDTH),
    parameter int CNT_WIDTH = 16,
    parameter int SUM_WIDTH = calc_sum_width(DW, CNT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] frame_len,
    input  logic                 abort,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SUM_WIDTH-1:0] sum_out,
    output logic [DW-1:0]        max_out,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    state_t               state;
    logic [SUM_WIDTH-1:0] sum_q;
    logic [DW-1:0]        max_q;
    logic                 accept;
    logic                 cnt_load;
    logic                 last;

    // in_ready is only ever high in ACCUM, so it alone qualifies an accept.
    assign accept   = in_valid & in_ready & ~abort;
    assign cnt_load = (state == IDLE) & start & ~abort;

    frame_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_frame_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(abort),
        .load (cnt_load),
        .len  (frame_len),
        .inc  (accept),
        .cnt  (cnt_out),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum_q     <= '0;
            max_q     <= '0;
        end else if (abort) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum_q     <= '0;
            max_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sum_q <= '0;
                        max_q <= '0;
                        busy  <= 1'b1;
                        // An empty frame completes immediately with zero results.
                        if (frame_len != '0) begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sum_q <= sum_q + SUM_WIDTH'(in_data);
                        if (in_data > max_q)
                            max_q <= in_data;
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A start arriving with out_ready is dropped, not queued.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign sum_out = sum_q;
    assign max_out = max_q;

endmodule

// File: tb/tb_abs_diff_accumulator.sv
// Self-checking bench for abs_diff_accumulator: table-driven frames with a
// result scoreboard plus hand-written hold, abort, reset and empty-frame cases.
module tb_abs_diff_accumulator;

    localparam int WIDTH     = 16;
    localparam int DW        = 2 * WIDTH + 1;
    localparam int CNT_WIDTH = 16;
    localparam int SUM_WIDTH = DW + CNT_WIDTH;

    typedef struct {
        logic [CNT_WIDTH-1:0]  len;
        logic [3:0][DW-1:0]    s;
        logic [3:0]            gap;
        logic [SUM_WIDTH-1:0]  sum;
        logic [DW-1:0]         mx;
        logic [CNT_WIDTH-1:0]  cnt;
    } vec_t;

    typedef struct {
        logic [SUM_WIDTH-1:0] sum;
        logic [DW-1:0]        mx;
        logic [CNT_WIDTH-1:0] cnt;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CNT_WIDTH-1:0] frame_len;
    logic                 abort;
    logic [DW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [SUM_WIDTH-1:0] sum_out;
    logic [DW-1:0]        max_out;
    logic [CNT_WIDTH-1:0] cnt_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t vecs[5];

    abs_diff_accumulator #(
        .WIDTH(WIDTH), .DW(DW), .CNT_WIDTH(CNT_WIDTH), .SUM_WIDTH(SUM_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sum_out(sum_out), .max_out(max_out), .cnt_out(cnt_out),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},     64'(busy),      64'd0);
        check({tag, "_in_ready"}, 64'(in_ready),  64'd0);
        check({tag, "_out_valid"},64'(out_valid), 64'd0);
        check({tag, "_sum"},      64'(sum_out),   64'd0);
        check({tag, "_max"},      64'(max_out),   64'd0);
        check({tag, "_cnt"},      64'(cnt_out),   64'd0);
    endtask

    // Start a frame, feed its samples and verify the result appears exactly
    // on the edge that accepts the last sample.
    task automatic run_frame(input vec_t v);
        sb.push_back('{sum: v.sum, mx: v.mx, cnt: v.cnt});
        start = 1'b1; frame_len = v.len;
        step();
        start = 1'b0;
        check("accum_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < int'(v.len); i++) begin
            if (v.gap[i]) begin
                in_valid = 1'b0;
                step();
                check("gap_hold_cnt", 64'(cnt_out), 64'(i));
            end
            in_valid = 1'b1; in_data = v.s[i];
            step();
            in_valid = 1'b0;
            check("accept_cnt", 64'(cnt_out), 64'(i + 1));
            check("out_valid_timing", 64'(out_valid), 64'(i == int'(v.len) - 1));
        end
    endtask

    // Pop the scoreboard, compare results, then hand them off.
    task automatic drain(input logic with_start);
        exp_t e;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_underflow: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        check("res_valid", 64'(out_valid), 64'd1);
        check("res_sum",   64'(sum_out),   64'(e.sum));
        check("res_max",   64'(max_out),   64'(e.mx));
        check("res_cnt",   64'(cnt_out),   64'(e.cnt));
        out_ready = 1'b1; start = with_start;
        step();
        out_ready = 1'b0; start = 1'b0;
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_busy",  64'(busy),      64'd0);
    endtask

    initial begin
        logic [SUM_WIDTH-1:0] big_sum;

        vecs[0] = '{len: 16'd4, s: {33'd1, 33'd7, 33'd10, 33'd3}, gap: 4'b0000,
                    sum: 49'd21, mx: 33'd10, cnt: 16'd4};
        vecs[1] = '{len: 16'd3, s: {33'd0, 33'd7, 33'd6, 33'd5}, gap: 4'b0110,
                    sum: 49'd18, mx: 33'd7, cnt: 16'd3};
        vecs[2] = '{len: 16'd2, s: {33'd0, 33'd0, 33'h0_FFFF_FFFF, 33'h1_0000_0000},
                    gap: 4'b0000, sum: 49'h1_FFFF_FFFF, mx: 33'h1_0000_0000, cnt: 16'd2};
        vecs[3] = '{len: 16'd1, s: {33'd0, 33'd0, 33'd0, 33'd0}, gap: 4'b0000,
                    sum: 49'd0, mx: 33'd0, cnt: 16'd1};
        vecs[4] = '{len: 16'd4, s: {33'd1, 33'd99, 33'd2, 33'd100}, gap: 4'b1001,
                    sum: 49'd202, mx: 33'd100, cnt: 16'd4};

        rst = 1'b1; start = 1'b0; frame_len = '0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        check_idle_zero("reset");
        rst = 1'b0;
        step();

        for (int k = 0; k < 5; k++) begin
            run_frame(vecs[k]);
            drain(1'b0);
        end

        // Long frame of all-ones samples: the sum must be exact with no wrap.
        big_sum = 49'd65535 * 49'h1_FFFF_FFFF;
        sb.push_back('{sum: big_sum, mx: {DW{1'b1}}, cnt: 16'd65535});
        start = 1'b1; frame_len = 16'd65535;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = {DW{1'b1}};
        for (int i = 0; i < 65534; i++) step();
        check("big_not_done_early", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        drain(1'b0);

        // Results held in DONE while the consumer stalls; stray inputs ignored.
        run_frame(vecs[0]);
        start = 1'b1; in_valid = 1'b1; in_data = 33'd999; frame_len = 16'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid",    64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready),  64'd0);
            check("hold_sum",      64'(sum_out),   64'd21);
            check("hold_max",      64'(max_out),   64'd10);
            check("hold_cnt",      64'(cnt_out),   64'd4);
        end
        in_valid = 1'b0;
        drain(1'b1);
        step();
        check("start_not_queued", 64'(busy), 64'd0);

        // Abort mid-frame.
        start = 1'b1; frame_len = 16'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 33'd50; step();
        in_data = 33'd60; step();
        in_valid = 1'b0;
        check("pre_abort_cnt", 64'(cnt_out), 64'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle_zero("abort");

        // Asynchronous reset mid-frame takes effect before any clock edge.
        start = 1'b1; frame_len = 16'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 33'd8; step(); step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_idle_zero("async_rst");
        step();
        rst = 1'b0;
        step();

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; frame_len = 16'd3;
        step();
        start = 1'b0; abort = 1'b0;
        check_idle_zero("start_abort");

        // Empty frame goes straight to DONE with zero results.
        sb.push_back('{sum: '0, mx: '0, cnt: '0});
        start = 1'b1; frame_len = 16'd0;
        step();
        start = 1'b0;
        check("empty_busy", 64'(busy), 64'd1);
        drain(1'b0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
